ipf_seq_ctrl: RTL and testbench

- Sequencer that drives one IPF convolution engine from two local buffers: a weight buffer and an input-line buffer.
- On a `go` pulse it streams the 3x3 or 5x5 weight set into IPF, then the input words for each weight group, generating ctrl, wgroup, stride and valid timing.
- It then waits for IPF `finish` and reports `done`.
- It replaces hand-written stimulus sequencing and sits between the layer controller and IPF.

---
 rtl/ipf_seq_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_ipf_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipf_seq_ctrl.sv
// IPF sequencer: streams weights then input words from local buffers
// into one IPF engine and waits for its finish.
module ipf_seq_ctrl #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 16,
  parameter int I_WORDS = 8,
  parameter int PASSES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [1:0]        cfg_wsize,
  input  logic              cfg_stride,
  input  logic [3:0]        cfg_ngroups,
  input  logic [2:0]        cfg_wround,
  input  logic [1:0]        cfg_padding,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              i_rd,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [1:0]        ipf_ctrl,
  output logic              ipf_w_valid,
  output logic [DATA_W-1:0] ipf_w_data,
  output logic              ipf_i_valid,
  output logic [DATA_W-1:0] ipf_i_data,
  output logic [1:0]        ipf_wsize,
  output logic              ipf_stride,
  output logic [1:0]        ipf_padding,
  output logic [3:0]        ipf_wgroup,
  output logic [2:0]        ipf_wround,
  input  logic              ipf_finish
);

  localparam int PW = $clog2(PASSES + 1);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(I_WORDS - 1);
  localparam logic [PW-1:0]     P_LAST = PW'(PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_STREAM, S_END, S_WAIT_FIN
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              w_rd_q, w_rd_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [ADDR_W-1:0] w_last_q, w_last_d;
  logic              i_rd_q, i_rd_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic [3:0]        grp_q, grp_d;
  logic [3:0]        g_last_q, g_last_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              w_vld_q, w_vld_d;
  logic              i_vld_q, i_vld_d;
  logic [3:0]        wgroup_q, wgroup_d;
  logic [1:0]        wsize_q, wsize_d;
  logic              stride_q, stride_d;
  logic [1:0]        padding_q, padding_d;
  logic [2:0]        wround_q, wround_d;
  logic              k_wrap, p_wrap, s_last;

  assign k_wrap = (i_addr_q == K_LAST);
  assign p_wrap = (pass_q == P_LAST);
  assign s_last = k_wrap && p_wrap && (grp_q == g_last_q);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    w_rd_d    = 1'b0;
    w_addr_d  = w_addr_q;
    w_last_d  = w_last_q;
    i_rd_d    = 1'b0;
    i_addr_d  = i_addr_q;
    pass_d    = pass_q;
    grp_d     = grp_q;
    g_last_d  = g_last_q;
    ctrl_d    = 2'd2;
    w_vld_d   = w_rd_q;
    i_vld_d   = i_rd_q;
    wgroup_d  = wgroup_q;
    wsize_d   = wsize_q;
    stride_d  = stride_q;
    padding_d = padding_q;
    wround_d  = wround_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          wsize_d   = cfg_wsize;
          stride_d  = cfg_stride;
          padding_d = cfg_padding;
          wround_d  = cfg_wround;
          if (cfg_wsize[1]) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d  = S_LOAD_W;
            busy_d   = 1'b1;
            w_rd_d   = 1'b1;
            w_addr_d = '0;
            w_last_d = cfg_wsize[0] ? ADDR_W'(24)
                                    : ADDR_W'(17);
            g_last_d = cfg_stride ? 4'd0 : cfg_ngroups;
          end
        end
      end
      S_LOAD_W: begin
        if (w_addr_q == w_last_q) begin
          state_d  = S_STREAM;
          i_rd_d   = 1'b1;
          i_addr_d = '0;
          pass_d   = '0;
          grp_d    = '0;
        end else begin
          w_rd_d   = 1'b1;
          w_addr_d = w_addr_q + 1'b1;
        end
      end
      S_STREAM: begin
        // tag the beat this read produces next cycle
        ctrl_d = (pass_q == '0 && i_addr_q < ADDR_W'(2))
                 ? 2'd2 : 2'd1;
        wgroup_d = stride_q ? {3'b000, i_addr_q[0]} : grp_q;
        if (s_last) begin
          state_d = S_END;
        end else begin
          i_rd_d = 1'b1;
          if (k_wrap) begin
            i_addr_d = '0;
            if (p_wrap) begin
              pass_d = '0;
              grp_d  = grp_q + 1'b1;
            end else begin
              pass_d = pass_q + 1'b1;
            end
          end else begin
            i_addr_d = i_addr_q + 1'b1;
          end
        end
      end
      S_END: begin
        ctrl_d  = 2'd0;
        state_d = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        ctrl_d = 2'd0;
        if (ipf_finish) begin
          ctrl_d  = 2'd2;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      w_rd_q    <= 1'b0;
      w_addr_q  <= '0;
      w_last_q  <= '0;
      i_rd_q    <= 1'b0;
      i_addr_q  <= '0;
      pass_q    <= '0;
      grp_q     <= '0;
      g_last_q  <= '0;
      ctrl_q    <= 2'd2;
      w_vld_q   <= 1'b0;
      i_vld_q   <= 1'b0;
      wgroup_q  <= '0;
      wsize_q   <= '0;
      stride_q  <= 1'b0;
      padding_q <= '0;
      wround_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      w_rd_q    <= w_rd_d;
      w_addr_q  <= w_addr_d;
      w_last_q  <= w_last_d;
      i_rd_q    <= i_rd_d;
      i_addr_q  <= i_addr_d;
      pass_q    <= pass_d;
      grp_q     <= grp_d;
      g_last_q  <= g_last_d;
      ctrl_q    <= ctrl_d;
      w_vld_q   <= w_vld_d;
      i_vld_q   <= i_vld_d;
      wgroup_q  <= wgroup_d;
      wsize_q   <= wsize_d;
      stride_q  <= stride_d;
      padding_q <= padding_d;
      wround_q  <= wround_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign w_rd        = w_rd_q;
  assign w_addr      = w_addr_q;
  assign i_rd        = i_rd_q;
  assign i_addr      = i_addr_q;
  assign ipf_ctrl    = ctrl_q;
  assign ipf_w_valid = w_vld_q;
  assign ipf_i_valid = i_vld_q;
  // buffer data arrives with the registered valid; gate it off between beats
  assign ipf_w_data  = w_vld_q ? w_rdata : '0;
  assign ipf_i_data  = i_vld_q ? i_rdata : '0;
  assign ipf_wsize   = wsize_q;
  assign ipf_stride  = stride_q;
  assign ipf_padding = padding_q;
  assign ipf_wgroup  = wgroup_q;
  assign ipf_wround  = wround_q;

endmodule

// File: tb/tb_ipf_seq_ctrl.sv
// Bench for ipf_seq_ctrl: directed scenarios plus random operations,
// checked every cycle against a timeline model of the sequence.
module tb_ipf_seq_ctrl;

  localparam int IW = 8;
  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic [1:0]  cfg_wsize = '0;
  logic        cfg_stride = 1'b0;
  logic [3:0]  cfg_ngroups = '0;
  logic [2:0]  cfg_wround = '0;
  logic [1:0]  cfg_padding = '0;
  logic        busy, done, err;
  logic        w_rd, i_rd;
  logic [15:0] w_addr, i_addr;
  logic [63:0] w_rdata = '0;
  logic [63:0] i_rdata = '0;
  logic [1:0]  ipf_ctrl;
  logic        ipf_w_valid, ipf_i_valid;
  logic [63:0] ipf_w_data, ipf_i_data;
  logic [1:0]  ipf_wsize, ipf_padding;
  logic        ipf_stride;
  logic [3:0]  ipf_wgroup;
  logic [2:0]  ipf_wround;
  logic        ipf_finish = 1'b0;

  ipf_seq_ctrl dut (
    .clk(clk), .rst(rst), .go(go),
    .cfg_wsize(cfg_wsize), .cfg_stride(cfg_stride),
    .cfg_ngroups(cfg_ngroups), .cfg_wround(cfg_wround),
    .cfg_padding(cfg_padding),
    .busy(busy), .done(done), .err(err),
    .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
    .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata),
    .ipf_ctrl(ipf_ctrl),
    .ipf_w_valid(ipf_w_valid), .ipf_w_data(ipf_w_data),
    .ipf_i_valid(ipf_i_valid), .ipf_i_data(ipf_i_data),
    .ipf_wsize(ipf_wsize), .ipf_stride(ipf_stride),
    .ipf_padding(ipf_padding), .ipf_wgroup(ipf_wgroup),
    .ipf_wround(ipf_wround), .ipf_finish(ipf_finish)
  );

  always #5 clk = ~clk;

  logic [63:0] wmem [32];
  logic [63:0] imem [IW];

  // buffers: data one cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    w_rdata <= w_rd ? wmem[w_addr[4:0]] : {$urandom, $urandom};
    i_rdata <= i_rd ? imem[i_addr[2:0]] : {$urandom, $urandom};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int cur_t;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d t=%0d act=%0h exp=%0h",
               nm, cyc, cur_t, act, exp);
    end
  endfunction

  // model state: 0 reset/idle, 1 legal op, 2 illegal op
  int   mode = 0;
  int   go_cyc = 0;
  int   m_nw, m_nb, m_ft, m_st;
  logic [1:0] m_ws, m_pad;
  logic [2:0] m_wr;

  logic        e_busy, e_done, e_err, e_wrd, e_ird;
  logic        e_wv, e_iv;
  logic [1:0]  e_ctrl;
  logic [15:0] e_waddr, e_iaddr;
  logic [63:0] e_wd, e_id;
  logic [3:0]  e_wg;
  int          j;

  always @(negedge clk) begin
    cur_t = cyc - go_cyc;
    e_busy = 0; e_done = 0; e_err = 0;
    e_wrd = 0; e_ird = 0; e_wv = 0; e_iv = 0;
    e_ctrl = 2'd2; e_waddr = 0; e_iaddr = 0;
    e_wd = 0; e_id = 0; e_wg = 0;
    if (mode == 1) begin
      e_busy = cur_t >= 1 && cur_t <= m_ft;
      e_done = cur_t == m_ft + 1;
      if (cur_t >= 1 && cur_t <= m_nw) begin
        e_wrd = 1;
        e_waddr = 16'(cur_t - 1);
      end
      if (cur_t >= 2 && cur_t <= m_nw + 1) begin
        e_wv = 1;
        e_wd = wmem[cur_t - 2];
      end
      if (cur_t >= m_nw + 1 && cur_t <= m_nw + m_nb) begin
        e_ird = 1;
        e_iaddr = 16'((cur_t - m_nw - 1) % IW);
      end
      j = cur_t - m_nw - 2;
      if (j >= 0 && j < m_nb) begin
        e_iv = 1;
        e_id = imem[j % IW];
        e_ctrl = (j % (IW * NP)) < 2 ? 2'd2 : 2'd1;
        e_wg = m_st != 0 ? 4'((j % IW) % 2) : 4'(j / (IW * NP));
      end
      if (cur_t >= m_nw + m_nb + 2 && cur_t <= m_ft)
        e_ctrl = 2'd0;
    end else if (mode == 2) begin
      e_done = cur_t == 1;
      e_err = cur_t == 1;
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("w_rd", w_rd, e_wrd);
    chk("i_rd", i_rd, e_ird);
    chk("ctrl", ipf_ctrl, e_ctrl);
    chk("w_valid", ipf_w_valid, e_wv);
    chk("w_data", ipf_w_data, e_wd);
    chk("i_valid", ipf_i_valid, e_iv);
    chk("i_data", ipf_i_data, e_id);
    if (e_wrd) chk("w_addr", w_addr, e_waddr);
    if (e_ird) chk("i_addr", i_addr, e_iaddr);
    if (e_iv) chk("wgroup", ipf_wgroup, e_wg);
    if (mode == 0 || (mode == 1 && cur_t >= 1)) begin
      chk("cfg_wsize", ipf_wsize, mode == 1 ? m_ws : 2'd0);
      chk("cfg_stride", ipf_stride, mode == 1 ? 1'(m_st) : 1'b0);
      chk("cfg_pad", ipf_padding, mode == 1 ? m_pad : 2'd0);
      chk("cfg_wround", ipf_wround, mode == 1 ? m_wr : 3'd0);
    end
  end

  task automatic scramble_cfg();
    cfg_wsize = 2'($urandom);
    cfg_stride = 1'($urandom);
    cfg_ngroups = 4'($urandom);
    cfg_wround = 3'($urandom);
    cfg_padding = 2'($urandom);
  endtask

  task automatic run_op(input int ws, input int st, input int ng,
                        input int fd, input bit gis, input bit fil,
                        input bit pin, input int rst_at);
    int nw, nb, ft;
    nw = ws != 0 ? 25 : 18;
    nb = IW * NP * (st != 0 ? 1 : ng + 1);
    ft = nw + nb + 1 + fd;
    @(posedge clk); #1;
    cfg_wsize = 2'(ws);
    cfg_stride = 1'(st);
    cfg_ngroups = 4'(ng);
    cfg_wround = 3'($urandom);
    cfg_padding = 2'($urandom);
    go = 1;
    m_ws = cfg_wsize; m_st = st;
    m_wr = cfg_wround; m_pad = cfg_padding;
    m_nw = nw; m_nb = nb; m_ft = ft;
    go_cyc = cyc; mode = 1;
    for (int t = 1; t <= ft + 2; t++) begin
      @(posedge clk); #1;
      scramble_cfg();
      go = gis && (t == nw + 5);
      ipf_finish = (fil && t == 3) || (t == ft);
      if (rst_at != 0 && t == rst_at) begin
        rst = 0; go = 0; ipf_finish = 0; mode = 0;
        @(negedge clk);
        chk("rst_ctrl", ipf_ctrl, 2'd2);
        chk("rst_iv", ipf_i_valid, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        return;
      end
      if (pin) begin
        @(negedge clk);
        case (t)
          19: chk("pin_wv19", ipf_w_valid, 1'b1);
          20: begin
            chk("pin_wv20", ipf_w_valid, 1'b0);
            chk("pin_iv20", ipf_i_valid, 1'b1);
            chk("pin_ctrl20", ipf_ctrl, 2'd2);
          end
          22: chk("pin_ctrl22", ipf_ctrl, 2'd1);
          35: chk("pin_wg35", ipf_wgroup, 4'd0);
          36: chk("pin_wg36", ipf_wgroup, 4'd1);
          51: chk("pin_iv51", ipf_i_valid, 1'b1);
          52: begin
            chk("pin_iv52", ipf_i_valid, 1'b0);
            chk("pin_ctrl52", ipf_ctrl, 2'd0);
          end
          56: chk("pin_busy56", busy, 1'b1);
          57: begin
            chk("pin_done57", done, 1'b1);
            chk("pin_busy57", busy, 1'b0);
            chk("pin_ctrl57", ipf_ctrl, 2'd2);
          end
          default: ;
        endcase
      end
    end
    go = 0;
    ipf_finish = 0;
  endtask

  task automatic run_err(input int ws);
    @(posedge clk); #1;
    cfg_wsize = 2'(ws);
    go = 1;
    go_cyc = cyc; mode = 2;
    @(posedge clk); #1;
    go = 0;
    @(negedge clk);
    chk("pin_err_done", done, 1'b1);
    chk("pin_err_err", err, 1'b1);
    chk("pin_err_busy", busy, 1'b0);
    for (int t = 2; t <= 4; t++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int a = 0; a < 32; a++) wmem[a] = {$urandom, $urandom};
    for (int a = 0; a < IW; a++) imem[a] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctrl0", ipf_ctrl, 2'd2);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    run_op(0, 0, 1, 5, 0, 0, 1, 0);
    run_op(0, 1, 7, 3, 0, 0, 0, 0);
    run_op(1, 0, 0, 2, 0, 0, 0, 0);
    run_err(3);
    run_err(2);
    run_op(0, 0, 1, 5, 0, 0, 0, 30);
    run_op(0, 0, 1, 5, 0, 0, 1, 0);
    run_op(0, 0, 1, 5, 1, 1, 1, 0);
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 4) == 0)
        run_err(int'($urandom_range(2, 3)));
      else
        run_op(int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)),
               int'($urandom_range(1, 6)),
               1'($urandom), 1'($urandom), 0, 0);
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
